// File: rtl/prng8_core_if.sv
// Random-byte stream bus for prng8_core: advance/reseed controls, seed and the output byte.
// The output is named rand_val because "rand" is a reserved SystemVerilog keyword.
interface prng8_core_if;
    logic       update;
    logic       reseed;
    logic [7:0] seed;
    logic [7:0] rand_val;

    modport master (output update, output reseed, output seed, input rand_val);
    modport slave  (input update, input reseed, input seed, output rand_val);
endinterface

// File: rtl/prng8_core.sv
// 8-bit Fibonacci-LFSR random byte source with reseed and all-zero avoidance.
// Optional output whitening counter enabled by defining PRNG8_WHITEN_EN.
module prng8_core #(
    parameter logic [7:0] TAPS       = 8'hB8,
    parameter logic [7:0] RESET_SEED = 8'h01,
    parameter logic [7:0] ZERO_SUB   = 8'h01
) (
    input logic          clk,
    input logic          nRst,
    prng8_core_if.slave  bus
);

    logic [7:0] state;
    logic       fb;

    // A zero seed would lock the LFSR, so it is swapped for a nonzero constant.
    function automatic logic [7:0] seed_sub(input logic [7:0] s);
        return (s == 8'h00) ? ZERO_SUB : s;
    endfunction

    assign fb = ^(state & TAPS);

    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            state <= RESET_SEED;
        end else if (bus.reseed) begin
            state <= seed_sub(bus.seed);
        end else if (bus.update) begin
            state <= {state[6:0], fb};
        end
    end

`ifdef PRNG8_WHITEN_EN
    logic [7:0] cnt;

    // Counter advances in lockstep with the LFSR so the combined period is 255*256.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            cnt <= 8'h00;
        end else if (bus.reseed) begin
            cnt <= 8'h00;
        end else if (bus.update) begin
            cnt <= cnt + 8'h01;
        end
    end

    assign bus.rand_val = state ^ cnt;
`else
    assign bus.rand_val = state;
`endif

endmodule

// File: tb/tb_prng8_core.sv
// Directed self-checking bench for prng8_core; expected bytes are hand-computed for TAPS=8'hB8.
module tb_prng8_core;

    logic clk;
    logic nRst;
    int   n_cmp;
    int   n_err;

    prng8_core_if bus ();

    prng8_core dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] s);
        bus.reseed = 1'b1;
        bus.seed   = s;
        tick();
        bus.reseed = 1'b0;
    endtask

    initial begin
        logic [7:0] seq_a [7];
        logic [7:0] seq_b [3];
        logic       seen  [256];
        int         distinct;
        int         zeros;

        n_cmp = 0;
        n_err = 0;
        seq_a = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        seq_b = '{8'h10, 8'h21, 8'h43};

        nRst       = 1'b1;
        bus.update = 1'b0;
        bus.reseed = 1'b0;
        bus.seed   = 8'h00;
        tick();
        tick();
        nRst = 1'b0;
        chk("reset_value", bus.rand_val, 8'h01);

`ifndef PRNG8_WHITEN_EN
        bus.update = 1'b1;
        foreach (seq_a[i]) begin
            tick();
            chk($sformatf("seq_a[%0d]", i), bus.rand_val, seq_a[i]);
        end

        // Reseed with update also high: seed must win, and seed changes are followed.
        bus.reseed = 1'b1;
        bus.seed   = 8'h88;
        tick();
        chk("reseed_88", bus.rand_val, 8'h88);
        bus.seed = 8'h55;
        tick();
        chk("reseed_follow_55", bus.rand_val, 8'h55);
        bus.seed = 8'h88;
        tick();
        chk("reseed_back_88", bus.rand_val, 8'h88);
        bus.reseed = 1'b0;
        foreach (seq_b[i]) begin
            tick();
            chk($sformatf("seq_b[%0d]", i), bus.rand_val, seq_b[i]);
        end

        bus.update = 1'b0;
        repeat (3) tick();
        chk("hold", bus.rand_val, 8'h43);

        load(8'hFF);
        chk("seed_ff", bus.rand_val, 8'hFF);
        bus.update = 1'b1;
        tick();
        chk("ff_step1", bus.rand_val, 8'hFE);
        tick();
        chk("ff_step2", bus.rand_val, 8'hFC);

        load(8'h00);
        chk("zero_sub", bus.rand_val, 8'h01);

        foreach (seen[i]) seen[i] = 1'b0;
        distinct = 0;
        for (int k = 0; k < 255; k++) begin
            if (!seen[bus.rand_val]) distinct++;
            seen[bus.rand_val] = 1'b1;
            tick();
        end
        chk("period_return", bus.rand_val, 8'h01);
        chk("period_distinct", distinct, 255);
        chk("period_no_zero", seen[0], 1'b0);

        zeros = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (bus.rand_val == 8'h00) zeros++;
        end
        chk("never_zero_1000", zeros, 0);

        // Asynchronous reset between edges, mid-sequence.
        load(8'h88);
        tick();
        #2;
        nRst = 1'b1;
        #1;
        chk("async_reset", bus.rand_val, 8'h01);
        nRst = 1'b0;
        tick();
        chk("after_reset_1", bus.rand_val, 8'h02);
        tick();
        chk("after_reset_2", bus.rand_val, 8'h04);

        // Reset asserted while reseed is active overrides the seed, across an edge too.
        bus.reseed = 1'b1;
        bus.seed   = 8'hAA;
        #2;
        nRst = 1'b1;
        #1;
        chk("async_reset_reseed", bus.rand_val, 8'h01);
        tick();
        chk("reset_held_edge", bus.rand_val, 8'h01);
        nRst = 1'b0;
        tick();
        chk("reseed_after_reset", bus.rand_val, 8'hAA);
        bus.reseed = 1'b0;
`else
        bus.update = 1'b1;
        tick();
        chk("wh_step1", bus.rand_val, 8'h03);
        tick();
        chk("wh_step2", bus.rand_val, 8'h06);
        tick();
        chk("wh_step3", bus.rand_val, 8'h0B);
        load(8'h88);
        chk("wh_reseed_88", bus.rand_val, 8'h88);
        tick();
        chk("wh_after_reseed", bus.rand_val, 8'h11);
        tick();
        chk("wh_after_reseed2", bus.rand_val, 8'h23);
        bus.update = 1'b0;
        repeat (2) tick();
        chk("wh_hold", bus.rand_val, 8'h23);
        load(8'h00);
        chk("wh_zero_sub", bus.rand_val, 8'h01);
        #2;
        nRst = 1'b1;
        #1;
        chk("wh_async_reset", bus.rand_val, 8'h01);
        nRst = 1'b0;
        bus.update = 1'b1;
        tick();
        chk("wh_after_reset", bus.rand_val, 8'h03);
        tick();
        chk("wh_after_reset2", bus.rand_val, 8'h06);
        tick();
        chk("wh_after_reset3", bus.rand_val, 8'h0B);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prng8_core.md
# prng8_core

8-bit pseudo-random number generator built on a maximal-length Fibonacci LFSR, used wherever a cheap, reseedable random byte stream is needed (test-pattern generation, jitter/dither sources, arbitration tie-breaking). It advances one step per enabled clock and can be reloaded from an external seed at any time. An all-zero lock-up state is never entered.

## Interface

- TAPS, 8'hB8, feedback tap mask; bit i set means state bit i is XORed into the feedback (default x^8+x^6+x^5+x^4+1, period 255); bit 7 must be set.
- RESET_SEED, 8'h01, state value loaded on reset; must be nonzero.
- ZERO_SUB, 8'h01, value substituted when a seed of 8'h00 is loaded; must be nonzero.
- clk  input  1  single clock; all state changes on its rising edge.
- nRst  input  1  reset, asynchronous and active-high (asserted when 1).
- update  input  1  advance enable; 1 = step the LFSR once per clock.
- reseed  input  1  seed load request, level-sensitive.
- seed  input  8  seed value sampled while reseed=1.
- rand  output  8  current random byte, driven directly from registers.

## Operation

- State: 8-bit register `state`; feedback fb = XOR-reduce(state AND TAPS); step: state <= {state[6:0], fb}.
- Priority per rising edge (nRst deasserted): reseed=1 -> state <= (seed==0 ? ZERO_SUB : seed); else update=1 -> one step; else hold.
- reseed has priority over update; while reseed stays 1, state reloads from seed every cycle (seed changes mid-reseed are followed).
- Zero substitution guarantees state never 0; with default TAPS the sequence visits all 255 nonzero values before repeating.
- Without whitening, rand = state.
- nRst asserted at any time (including mid-reseed or mid-update) immediately forces state <= RESET_SEED and any whitening counter to 0, regardless of clk.

## Timing

- Reset value: rand = 8'h01 (RESET_SEED) without whitening; 8'h01 with whitening (counter 0).
- Update latency: rand changes one clock after the edge where update=1 is sampled; one step per cycle, no bubbles.
- Reseed latency: rand = seed (or ZERO_SUB) after the first rising edge with reseed=1.
- First step after reseed release occurs on the first edge with reseed=0 and update=1.
- No handshake; inputs sampled synchronously; rand has no combinational path from any input.

## Configuration

- PRNG8_WHITEN_EN defined: add 8-bit counter `cnt`, reset to 0, cleared to 0 on any reseed cycle, incremented (mod 256) on each LFSR step; rand = state XOR cnt. Combined output period 255*256 with default TAPS.
- PRNG8_WHITEN_EN undefined: no counter; rand = state exactly.

## Test plan

- Reset, update=1, reseed=0 -> rand sequence 01, 02, 04, 08, 11, 23, 47, 8E on consecutive clocks (whitening off).
- reseed=1 with seed=8'h88 for >=1 edge, then release with update=1 -> rand 88, then 10, 21, 43.
- Seed 8'hFF then step -> FE, FC; seed 8'h00 -> rand = 01 (ZERO_SUB), never 00 over 1000 subsequent steps.
- update=0 after several steps -> rand holds; reseed=1 with update=1 simultaneously -> seed wins; run 255 steps from 01 -> returns to 01, all nonzero values seen exactly once.
- Assert nRst asynchronously between clock edges mid-sequence -> rand = 01 immediately, no clock needed; sequence restarts 02, 04 after release.
- PRNG8_WHITEN_EN defined: reset then update=1 -> rand 01, 03 (02^01), 06 (04^02), 0B (08^03); reseed 8'h88 -> rand 88 with cnt cleared.
